sprite_blitter: RTL and testbench
=================================

// Module: sprite_blitter
// PURPOSE
//  Pixel-plot engine feeding vga_xy_controller's x/y/color inputs on a 160x120, 3-bit colour framebuffer.
//  Tracks a requested sprite position (x,y) from switches or game logic.
//  On each position change it erases the old 8x8 sprite to background, then draws the new one from sprite_rom.
//  Emits one pixel per clock. Downstream writes every cycle, so outputs always carry a valid, idempotent pixel.
// PARAMETERS
//  SPR_W     8       sprite width, pixels
//  SPR_H     8       sprite height, pixels
//  XMAX      160     screen width; valid x = 0..XMAX-1
//  YMAX      120     screen height; valid y = 0..YMAX-1
//  BG_COLOR  3'b000  erase/background colour
// PORTS
//  VGA_CLK  in   1  sole clock (pixel clock from vga_xy_controller)
//  reset    in   1  synchronous, active-high reset
//  x        in   8  requested sprite left column
//  y        in   7  requested sprite top row
//  xvga     out  8  pixel x to controller
//  yvga     out  7  pixel y to controller
//  color    out  3  pixel colour to controller
//  busy     out  1  high while in CLEAR, ERASE or DRAW
//  done     out  1  one-cycle pulse, coincident with output of last DRAW pixel
// BEHAVIOUR
//  - Reset: xvga=0, yvga=0, color=BG_COLOR, busy=0, done=0, cur_x=cur_y=0, pixel counter=0.
//    First state after reset is DRAW at (0,0), or CLEAR if the optional feature is enabled.
//  - Input saturation: x_s = min(x, XMAX-1); y_s = min(y, YMAX-1).
//  - States: IDLE, ERASE, DRAW (+CLEAR if enabled).
//  - IDLE:
//    - {x_s,y_s} != {cur_x,cur_y}: go to ERASE, counter=0.
//    - Otherwise stay in IDLE; outputs hold the last emitted pixel.
//  - x/y are sampled only in IDLE. Changes during ERASE/DRAW are ignored until IDLE is re-entered.
//  - ERASE: counter 0..SPR_W*SPR_H-1, row-major, column inner.
//    - Pixel (c,r) -> xvga=cur_x+c, yvga=cur_y+r, color=BG_COLOR.
//    - After the last pixel: latch cur_x=x_s, cur_y=y_s, counter=0, go to DRAW.
//  - DRAW: same scan at the new cur_x/cur_y; color = sprite_rom[r*SPR_W+c].
//    - After the last pixel: done=1 for that cycle, go to IDLE.
//  - Outputs are registered.
//    - State becomes ERASE at edge k, so pixel 0 appears after edge k+1.
//    - ERASE 63 appears at k+64, DRAW 0 at k+65, DRAW 63 (with done) at k+128.
//  - Clipping: sums cur_x+c and cur_y+r are computed 9/8 bits wide.
//    - If sum >= XMAX or >= YMAX, xvga/yvga/color hold their previous value (re-write, no wrap).
//    - The counter still advances, so timing is position-independent.
//  - Reset asserted mid-operation aborts immediately to reset values; no partial-erase recovery.
// CONFIGURATION
//  - Macro SPRITE_BLITTER_CLEAR_ON_RESET_EN:
//    - Defined: after reset, state CLEAR sweeps all XMAX*YMAX pixels row-major with BG_COLOR
//      (19200 cycles, busy=1), then enters DRAW at (0,0).
//    - Undefined: no CLEAR state; DRAW at (0,0) immediately after reset; screen contents are undefined outside the sprite.
// STRUCTURE
//  - Package sprite_pkg: XMAX, YMAX, SPR_W, SPR_H, BG_COLOR defaults, state enum (IDLE/CLEAR/ERASE/DRAW), colour constants.
//  - Sub-module sprite_rom: combinational, addr[5:0] -> color[2:0], 64-entry case table.
//  - Top level: FSM, pixel counter, position registers, clip compare, output registers.
// TESTING
//  1. Reset, x=0, y=0, no macro:
//     -> 64 DRAW pixels (0,0)..(7,7) with ROM colours; done on cycle 64; busy low afterwards; outputs stable.
//  2. From IDLE at (0,0), set x=10, y=20:
//     -> 64 BG pixels at (0..7,0..7), then DRAW at (10..17,20..27); done exactly 128 cycles after the ERASE edge.
//  3. x=156, y=118:
//     -> pixels with x>=160 or y>=120 hold the prior output; no xvga>159 or yvga>119 ever appears; total still 64+64 cycles.
//  4. x=200, y=127:
//     -> position latched as (159,119); only pixel (159,119) is written in-range per phase.
//  5. Change x mid-DRAW:
//     -> current DRAW completes at the old target; the next IDLE detects the change and starts a new ERASE.
//  6. Macro defined, reset:
//     -> 19200 BG writes covering (0,0)..(159,119), busy=1 throughout, then DRAW at (0,0).
//     Assert reset mid-CLEAR -> outputs return to reset values the next cycle.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants, state encoding and colour names for the sprite blitter.
package sprite_pkg;

  localparam int unsigned SPR_W = 8;
  localparam int unsigned SPR_H = 8;
  localparam int unsigned XMAX  = 160;
  localparam int unsigned YMAX  = 120;

  localparam logic [2:0] C_BLACK  = 3'b000;
  localparam logic [2:0] C_BLUE   = 3'b001;
  localparam logic [2:0] C_GREEN  = 3'b010;
  localparam logic [2:0] C_RED    = 3'b100;
  localparam logic [2:0] C_YELLOW = 3'b110;
  localparam logic [2:0] BG_COLOR = C_BLACK;

  localparam logic [7:0] X_LAST   = 8'(XMAX - 1);
  localparam logic [6:0] Y_LAST   = 7'(YMAX - 1);
  localparam logic [5:0] PIX_LAST = 6'(SPR_W * SPR_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ERASE = 2'd2,
    ST_DRAW  = 2'd3
  } state_t;

endpackage

// File: rtl/sprite_rom.sv
// 8x8 sprite bitmap: red border, blue/green checker interior, yellow 2x2 centre.
module sprite_rom
  import sprite_pkg::*;
(
  input  logic [5:0] addr,
  output logic [2:0] color
);

  // Row-major lookup, address = row*8 + column.
  always_comb begin
    color = BG_COLOR;
    case (addr)
      6'd0,  6'd1,  6'd2,  6'd3,  6'd4,  6'd5,  6'd6,  6'd7,
      6'd8,  6'd15, 6'd16, 6'd23, 6'd24, 6'd31, 6'd32, 6'd39,
      6'd40, 6'd47, 6'd48, 6'd55,
      6'd56, 6'd57, 6'd58, 6'd59, 6'd60, 6'd61, 6'd62, 6'd63: color = C_RED;
      6'd27, 6'd28, 6'd35, 6'd36:                             color = C_YELLOW;
      6'd10, 6'd12, 6'd14, 6'd17, 6'd19, 6'd21,
      6'd26, 6'd30, 6'd33, 6'd37,
      6'd42, 6'd44, 6'd46, 6'd49, 6'd51, 6'd53:               color = C_GREEN;
      6'd9,  6'd11, 6'd13, 6'd18, 6'd20, 6'd22,
      6'd25, 6'd29, 6'd34, 6'd38,
      6'd41, 6'd43, 6'd45, 6'd50, 6'd52, 6'd54:               color = C_BLUE;
      default:                                                color = BG_COLOR;
    endcase
  end

endmodule

// File: rtl/sprite_blitter.sv
// Erase-then-draw 8x8 sprite plotter emitting one pixel per clock to a 160x120 framebuffer.
// Optional full-screen clear after reset: define SPRITE_BLITTER_CLEAR_ON_RESET_EN.
module sprite_blitter
  import sprite_pkg::*;
(
  input  logic       VGA_CLK,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [6:0] y,
  output logic [7:0] xvga,
  output logic [6:0] yvga,
  output logic [2:0] color,
  output logic       busy,
  output logic       done
);

`ifdef SPRITE_BLITTER_CLEAR_ON_RESET_EN
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  localparam state_t RESET_STATE = ST_DRAW;
`endif

  state_t     state_r, state_s;
  logic [5:0] cnt_r, cnt_s;
  logic [7:0] cur_x_r, cur_x_s, tgt_x_r, tgt_x_s;
  logic [6:0] cur_y_r, cur_y_s, tgt_y_r, tgt_y_s;
  logic [7:0] xvga_r, pix_x_s;
  logic [6:0] yvga_r, pix_y_s;
  logic [2:0] color_r, pix_c_s, rom_color_s;
  logic       busy_r, done_r, done_s, pix_we_s;
  logic [7:0] x_sat_s;
  logic [6:0] y_sat_s;
  logic [8:0] sum_x_s;
  logic [7:0] sum_y_s;
  logic       in_range_s, pos_chg_s;

  assign x_sat_s   = (x > X_LAST) ? X_LAST : x;
  assign y_sat_s   = (y > Y_LAST) ? Y_LAST : y;
  assign pos_chg_s = ({x_sat_s, y_sat_s} != {cur_x_r, cur_y_r});

  // Widened sums so an off-screen pixel is detected instead of wrapping.
  assign sum_x_s    = {1'b0, cur_x_r} + {6'b000000, cnt_r[2:0]};
  assign sum_y_s    = {1'b0, cur_y_r} + {5'b00000, cnt_r[5:3]};
  assign in_range_s = (sum_x_s <= {1'b0, X_LAST}) && (sum_y_s <= {1'b0, Y_LAST});

  sprite_rom u_rom (
    .addr  (cnt_r),
    .color (rom_color_s)
  );

`ifdef SPRITE_BLITTER_CLEAR_ON_RESET_EN
  logic [7:0] clr_x_r;
  logic [6:0] clr_y_r;
  logic       clr_last_s;

  assign clr_last_s = (clr_x_r == X_LAST) && (clr_y_r == Y_LAST);

  // Row-major full-screen sweep position for the post-reset clear.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      clr_x_r <= 8'd0;
      clr_y_r <= 7'd0;
    end else if (state_r == ST_CLEAR) begin
      if (clr_x_r == X_LAST) begin
        clr_x_r <= 8'd0;
        clr_y_r <= clr_y_r + 7'd1;
      end else begin
        clr_x_r <= clr_x_r + 8'd1;
      end
    end else begin
      clr_x_r <= clr_x_r;
      clr_y_r <= clr_y_r;
    end
  end
`endif

  // Next-state, scan counter, position latching and the pixel to emit.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    cur_x_s  = cur_x_r;
    cur_y_s  = cur_y_r;
    tgt_x_s  = tgt_x_r;
    tgt_y_s  = tgt_y_r;
    pix_we_s = 1'b0;
    pix_x_s  = sum_x_s[7:0];
    pix_y_s  = sum_y_s[6:0];
    pix_c_s  = BG_COLOR;
    done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pos_chg_s) begin
          state_s = ST_ERASE;
          cnt_s   = 6'd0;
          tgt_x_s = x_sat_s;
          tgt_y_s = y_sat_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ERASE: begin
        pix_we_s = in_range_s;
        cnt_s    = cnt_r + 6'd1;
        if (cnt_r == PIX_LAST) begin
          state_s = ST_DRAW;
          cnt_s   = 6'd0;
          cur_x_s = tgt_x_r;
          cur_y_s = tgt_y_r;
        end else begin
          state_s = ST_ERASE;
        end
      end
      ST_DRAW: begin
        pix_we_s = in_range_s;
        pix_c_s  = rom_color_s;
        cnt_s    = cnt_r + 6'd1;
        if (cnt_r == PIX_LAST) begin
          state_s = ST_IDLE;
          cnt_s   = 6'd0;
          done_s  = 1'b1;
        end else begin
          state_s = ST_DRAW;
        end
      end
      ST_CLEAR: begin
`ifdef SPRITE_BLITTER_CLEAR_ON_RESET_EN
        pix_we_s = 1'b1;
        pix_x_s  = clr_x_r;
        pix_y_s  = clr_y_r;
        if (clr_last_s) begin
          state_s = ST_DRAW;
          cnt_s   = 6'd0;
        end else begin
          state_s = ST_CLEAR;
        end
`else
        state_s = ST_IDLE;
`endif
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM and position state.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      state_r <= RESET_STATE;
      cnt_r   <= 6'd0;
      cur_x_r <= 8'd0;
      cur_y_r <= 7'd0;
      tgt_x_r <= 8'd0;
      tgt_y_r <= 7'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      cur_x_r <= cur_x_s;
      cur_y_r <= cur_y_s;
      tgt_x_r <= tgt_x_s;
      tgt_y_r <= tgt_y_s;
    end
  end

  // Output registers; off-screen pixels re-emit the previous pixel.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      xvga_r  <= 8'd0;
      yvga_r  <= 7'd0;
      color_r <= BG_COLOR;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      if (pix_we_s) begin
        xvga_r  <= pix_x_s;
        yvga_r  <= pix_y_s;
        color_r <= pix_c_s;
      end else begin
        xvga_r  <= xvga_r;
        yvga_r  <= yvga_r;
        color_r <= color_r;
      end
      busy_r <= (state_s != ST_IDLE);
      done_r <= done_s;
    end
  end

  assign xvga  = xvga_r;
  assign yvga  = yvga_r;
  assign color = color_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed self-checking bench for sprite_blitter (default build, no full-screen clear).
module tb_sprite_blitter;

  logic       VGA_CLK = 1'b0;
  logic       reset;
  logic [7:0] x;
  logic [6:0] y;
  logic [7:0] xvga;
  logic [6:0] yvga;
  logic [2:0] color;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  int         cur_xm, cur_ym;
  logic [7:0] ex;
  logic [6:0] ey;
  logic [2:0] ec;

  sprite_blitter dut (
    .VGA_CLK (VGA_CLK),
    .reset   (reset),
    .x       (x),
    .y       (y),
    .xvga    (xvga),
    .yvga    (yvga),
    .color   (color),
    .busy    (busy),
    .done    (done)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  function automatic logic [2:0] rom_model(int c, int r);
    if (r == 0 || r == 7 || c == 0 || c == 7) return 3'b100;
    if (r >= 3 && r <= 4 && c >= 3 && c <= 4) return 3'b110;
    if (((r + c) % 2) == 1) return 3'b010;
    return 3'b001;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic exp_done, input logic exp_busy);
    check({tag, ".xvga"},  xvga,          ex);
    check({tag, ".yvga"},  8'(yvga),      8'(ey));
    check({tag, ".color"}, 8'(color),     8'(ec));
    check({tag, ".done"},  8'(done),      8'(exp_done));
    check({tag, ".busy"},  8'(busy),      8'(exp_busy));
  endtask

  task automatic pix(input int px, input int py, input logic [2:0] pc);
    if (px < 160 && py < 120) begin
      ex = px[7:0];
      ey = py[6:0];
      ec = pc;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    x = 8'd0;
    y = 7'd0;
    @(negedge VGA_CLK);
    ex = 8'd0; ey = 7'd0; ec = 3'b000;
    check_out("reset", 1'b0, 1'b0);
    cur_xm = 0; cur_ym = 0;
    reset = 1'b0;
  endtask

  task automatic init_draw();
    for (int i = 0; i < 64; i++) begin
      @(negedge VGA_CLK);
      pix(i % 8, i / 8, rom_model(i % 8, i / 8));
      check_out("init_draw", i == 63, i != 63);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge VGA_CLK);
      check_out("idle", 1'b0, 1'b0);
    end
  endtask

  task automatic move(input logic [7:0] rx, input logic [6:0] ry, input bit mid, input logic [7:0] mx);
    int nx, ny, c, r;
    x = rx;
    y = ry;
    nx = (rx > 8'd159) ? 159 : int'(rx);
    ny = (ry > 7'd119) ? 119 : int'(ry);
    @(negedge VGA_CLK);
    check_out("start", 1'b0, 1'b1);
    for (int j = 0; j < 128; j++) begin
      if (mid && j == 80) x = mx;
      @(negedge VGA_CLK);
      c = j % 8;
      r = (j / 8) % 8;
      if (j < 64) pix(cur_xm + c, cur_ym + r, 3'b000);
      else        pix(nx + c, ny + r, rom_model(c, r));
      check_out((j < 64) ? "erase" : "draw", j == 127, j != 127);
    end
    cur_xm = nx;
    cur_ym = ny;
  endtask

  initial begin
    reset = 1'b1;
    x = 8'd0;
    y = 7'd0;
    @(negedge VGA_CLK);
    do_reset();
    init_draw();
    idle(4);

    move(8'd10, 7'd20, 1'b0, 8'd0);
    idle(2);

    // Partially off-screen at the right/bottom edges.
    move(8'd156, 7'd118, 1'b0, 8'd0);
    idle(2);

    // Out-of-range request saturates to (159,119).
    move(8'd200, 7'd127, 1'b0, 8'd0);
    idle(2);

    // A different raw value that saturates to the same position is not a move.
    x = 8'd220;
    idle(3);

    // Change mid-DRAW: finish at (40,50), then a fresh move to (60,50).
    move(8'd40, 7'd50, 1'b1, 8'd60);
    move(8'd60, 7'd50, 1'b0, 8'd0);
    idle(2);

    // Reset in the middle of an erase.
    x = 8'd30;
    y = 7'd5;
    repeat (20) @(negedge VGA_CLK);
    do_reset();
    init_draw();
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
